// File: rtl/cond_status_unit.sv
// Condition-code unit: architectural flags {N,Z,C,V}, a shadow copy, and a condition test that sees this cycle's flag update.
// One-cycle result latency; a request is accepted every cycle, so there is never backpressure.
module cond_status_unit (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       alu_valid,
   input  logic       s_bit,
   input  logic       arith,
   input  logic       alu_c,
   input  logic       alu_n,
   input  logic       alu_v,
   input  logic       alu_z,
   input  logic       cond_valid,
   input  logic [3:0] cond,
   input  logic       save_req,
   input  logic       restore_req,
   output logic [3:0] flags,
   output logic       cond_true,
   output logic       cond_out_valid,
   output logic [3:0] shadow
);

   localparam logic [3:0] C_EQ = 4'b0000;
   localparam logic [3:0] C_NE = 4'b0001;
   localparam logic [3:0] C_CS = 4'b0010;
   localparam logic [3:0] C_CC = 4'b0011;
   localparam logic [3:0] C_MI = 4'b0100;
   localparam logic [3:0] C_PL = 4'b0101;
   localparam logic [3:0] C_VS = 4'b0110;
   localparam logic [3:0] C_VC = 4'b0111;
   localparam logic [3:0] C_HI = 4'b1000;
   localparam logic [3:0] C_LS = 4'b1001;
   localparam logic [3:0] C_GE = 4'b1010;
   localparam logic [3:0] C_LT = 4'b1011;
   localparam logic [3:0] C_GT = 4'b1100;
   localparam logic [3:0] C_LE = 4'b1101;
   localparam logic [3:0] C_AL = 4'b1110;

   logic [3:0] r_flags;
   logic [3:0] r_shadow;
   logic       r_cond_true;
   logic       r_cond_out_valid;

   logic       w_wr_alu;
   logic [3:0] w_flags_nxt;
   logic       w_n;
   logic       w_z;
   logic       w_c;
   logic       w_v;
   logic       w_cond_hit;

   assign w_wr_alu = alu_valid & s_bit;

   // Restore beats an ALU write; logical ops keep the previous C and V.
   always_comb begin
      w_flags_nxt = r_flags;
      if (restore_req) begin
         w_flags_nxt = r_shadow;
      end else if (w_wr_alu) begin
         if (arith) begin
            w_flags_nxt = {alu_n, alu_z, alu_c, alu_v};
         end else begin
            w_flags_nxt = {alu_n, alu_z, r_flags[1], r_flags[0]};
         end
      end
   end

   assign w_n = w_flags_nxt[3];
   assign w_z = w_flags_nxt[2];
   assign w_c = w_flags_nxt[1];
   assign w_v = w_flags_nxt[0];

   // Tested against the post-update flags so a dependent branch never waits.
   always_comb begin
      w_cond_hit = 1'b0;
      case (cond)
         C_EQ:    w_cond_hit = w_z;
         C_NE:    w_cond_hit = ~w_z;
         C_CS:    w_cond_hit = w_c;
         C_CC:    w_cond_hit = ~w_c;
         C_MI:    w_cond_hit = w_n;
         C_PL:    w_cond_hit = ~w_n;
         C_VS:    w_cond_hit = w_v;
         C_VC:    w_cond_hit = ~w_v;
         C_HI:    w_cond_hit = w_c & ~w_z;
         C_LS:    w_cond_hit = ~w_c | w_z;
         C_GE:    w_cond_hit = (w_n == w_v);
         C_LT:    w_cond_hit = (w_n != w_v);
         C_GT:    w_cond_hit = ~w_z & (w_n == w_v);
         C_LE:    w_cond_hit = w_z | (w_n != w_v);
         C_AL:    w_cond_hit = 1'b1;
         default: w_cond_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_flags          <= 4'b0000;
         r_shadow         <= 4'b0000;
         r_cond_true      <= 1'b0;
         r_cond_out_valid <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         // A simultaneous restore wins, and the shadow is left as it was.
         if (save_req && !restore_req) begin
            r_shadow <= r_flags;
         end
         r_cond_out_valid <= cond_valid;
         if (cond_valid) begin
            r_cond_true <= w_cond_hit;
         end
      end
   end

   assign flags          = r_flags;
   assign shadow         = r_shadow;
   assign cond_true      = r_cond_true;
   assign cond_out_valid = r_cond_out_valid;

endmodule

// File: tb/tb_cond_status_unit.sv
// Bench for cond_status_unit: hand-computed vector table, then a full condition x flags sweep.
module tb_cond_status_unit;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       alu_valid;
   logic       s_bit;
   logic       arith;
   logic       alu_c;
   logic       alu_n;
   logic       alu_v;
   logic       alu_z;
   logic       cond_valid;
   logic [3:0] cond;
   logic       save_req;
   logic       restore_req;
   logic [3:0] flags;
   logic       cond_true;
   logic       cond_out_valid;
   logic [3:0] shadow;

   cond_status_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .alu_valid      (alu_valid),
      .s_bit          (s_bit),
      .arith          (arith),
      .alu_c          (alu_c),
      .alu_n          (alu_n),
      .alu_v          (alu_v),
      .alu_z          (alu_z),
      .cond_valid     (cond_valid),
      .cond           (cond),
      .save_req       (save_req),
      .restore_req    (restore_req),
      .flags          (flags),
      .cond_true      (cond_true),
      .cond_out_valid (cond_out_valid),
      .shadow         (shadow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst_n;
      logic       av;
      logic       s;
      logic       ar;
      logic [3:0] alu;
      logic       cv;
      logic [3:0] cd;
      logic       sv;
      logic       rs;
      logic [3:0] e_flags;
      logic [3:0] e_shadow;
      logic       e_ct;
      logic       e_cov;
   } vec_t;

   typedef struct {
      string      name;
      logic [3:0] e_flags;
      logic [3:0] e_shadow;
      logic       e_ct;
      logic       e_cov;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input string nm, input logic rst_n, input logic av,
                               input logic s, input logic ar, input logic [3:0] alu,
                               input logic cv, input logic [3:0] cd, input logic sv,
                               input logic rs, input logic [3:0] ef, input logic [3:0] es,
                               input logic ect, input logic ecov);
      vec_t v;
      v.name = nm; v.rst_n = rst_n; v.av = av; v.s = s; v.ar = ar; v.alu = alu;
      v.cv = cv; v.cd = cd; v.sv = sv; v.rs = rs;
      v.e_flags = ef; v.e_shadow = es; v.e_ct = ect; v.e_cov = ecov;
      return v;
   endfunction

   // Reference condition table, f = {N,Z,C,V}.
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cc;
         4'd3:  return !cc;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cc && !z;
         4'd9:  return !cc || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply(input vec_t v);
      exp_t e;
      exp_t got;
      reset_n     = v.rst_n;
      alu_valid   = v.av;
      s_bit       = v.s;
      arith       = v.ar;
      {alu_n, alu_z, alu_c, alu_v} = v.alu;
      cond_valid  = v.cv;
      cond        = v.cd;
      save_req    = v.sv;
      restore_req = v.rs;
      e.name = v.name; e.e_flags = v.e_flags; e.e_shadow = v.e_shadow;
      e.e_ct = v.e_ct; e.e_cov = v.e_cov;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      n_vec++;
      if (flags !== got.e_flags || shadow !== got.e_shadow ||
          cond_true !== got.e_ct || cond_out_valid !== got.e_cov) begin
         n_err++;
         $display("FAIL %s: got flags=%b shadow=%b cond_true=%b cov=%b, expected flags=%b shadow=%b cond_true=%b cov=%b",
                  got.name, flags, shadow, cond_true, cond_out_valid,
                  got.e_flags, got.e_shadow, got.e_ct, got.e_cov);
      end
   endtask

   vec_t tbl[$];

   initial begin
      //             name          rst av s ar alu      cv cond     sv rs   flags    shadow   ct cov
      tbl.push_back(mk("reset",      0, 1,1,1, 4'b1111, 1,4'b1110, 1,0, 4'b0000,4'b0000, 0,0));
      tbl.push_back(mk("rst_hold",   0, 1,1,1, 4'b1011, 1,4'b1110, 1,1, 4'b0000,4'b0000, 0,0));
      tbl.push_back(mk("rel_nocv",   1, 0,0,0, 4'b0000, 0,4'b0000, 0,0, 4'b0000,4'b0000, 0,0));
      tbl.push_back(mk("bypass_eq",  1, 1,1,1, 4'b0100, 1,4'b0000, 0,0, 4'b0100,4'b0000, 1,1));
      tbl.push_back(mk("idle_hold",  1, 0,0,0, 4'b0000, 0,4'b0000, 0,0, 4'b0100,4'b0000, 1,0));
      tbl.push_back(mk("set_0011",   1, 1,1,1, 4'b0011, 1,4'b0010, 0,0, 4'b0011,4'b0000, 1,1));
      tbl.push_back(mk("logic_lt",   1, 1,1,0, 4'b1000, 1,4'b1011, 0,0, 4'b1011,4'b0000, 0,1));
      tbl.push_back(mk("gt",         1, 0,0,0, 4'b0000, 1,4'b1100, 0,0, 4'b1011,4'b0000, 1,1));
      tbl.push_back(mk("no_valid",   1, 0,1,1, 4'b1111, 1,4'b1110, 0,0, 4'b1011,4'b0000, 1,1));
      tbl.push_back(mk("set_1010",   1, 1,1,1, 4'b1010, 0,4'b0000, 0,0, 4'b1010,4'b0000, 1,0));
      tbl.push_back(mk("save",       1, 0,0,0, 4'b0000, 0,4'b0000, 1,0, 4'b1010,4'b1010, 1,0));
      tbl.push_back(mk("set_0001",   1, 1,1,1, 4'b0001, 1,4'b0110, 0,0, 4'b0001,4'b1010, 1,1));
      tbl.push_back(mk("rest_vs_wr", 1, 1,1,1, 4'b1111, 1,4'b0000, 0,1, 4'b1010,4'b1010, 0,1));
      tbl.push_back(mk("set_1001",   1, 1,1,1, 4'b1001, 0,4'b0000, 0,0, 4'b1001,4'b1010, 0,0));
      tbl.push_back(mk("save_1001",  1, 0,0,0, 4'b0000, 0,4'b0000, 1,0, 4'b1001,4'b1001, 0,0));
      tbl.push_back(mk("set_0110",   1, 1,1,1, 4'b0110, 1,4'b0001, 0,0, 4'b0110,4'b1001, 0,1));
      tbl.push_back(mk("save_rest",  1, 0,0,0, 4'b0000, 1,4'b0100, 1,1, 4'b1001,4'b1001, 1,1));
      tbl.push_back(mk("reset2",     0, 0,0,0, 4'b0000, 0,4'b0000, 0,0, 4'b0000,4'b0000, 0,0));
      tbl.push_back(mk("sbit0",      1, 1,0,1, 4'b0100, 1,4'b0000, 0,0, 4'b0000,4'b0000, 0,1));
      tbl.push_back(mk("set_1111",   1, 1,1,1, 4'b1111, 1,4'b1110, 0,0, 4'b1111,4'b0000, 1,1));
      tbl.push_back(mk("mid_reset",  0, 1,1,1, 4'b1111, 1,4'b1110, 1,0, 4'b0000,4'b0000, 0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // Back-to-back sweep: each cycle writes flags f and tests cond c against them.
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            logic [3:0] fv;
            logic [3:0] cv4;
            fv  = 4'(f);
            cv4 = 4'(c);
            apply(mk("sweep", 1, 1,1,1, fv, 1,cv4, 0,0, fv,4'b0000, cond_ref(cv4, fv),1));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
